// File: rtl/my_ps2_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the clock, issues request-to-send,
// shifts one byte plus odd parity and stop on device clock falling edges, then checks the ACK.
module my_ps2_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       done,
   output logic       err,
   output logic       timeout
);

   // state      | meaning
   // IDLE       | lines released, ready for a command
   // INHIBIT    | clock held low for INHIBIT_CYCLES
   // START      | clock and data both held low for one cycle
   // SEND       | clock released, data bits shifted out on device falling edges
   // ACK        | stop bit driven, device ACK sampled on next falling edge
   // WAIT_IDLE  | waiting for both lines to return high
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } state_t;

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q;
   logic [2:0]    clk_sync_q;
   logic [1:0]    data_sync_q;
   logic [9:0]    frame_q;
   logic [3:0]    idx_q;
   logic [IW-1:0] inh_q;
   logic [TW-1:0] wd_q;
   logic          nack_q;
   logic          clk_oe_q;
   logic          data_oe_q;
   logic          ready_q;
   logic          done_q;
   logic          err_q;
   logic          to_q;

   logic fe;
   logic wd_active;
   logic wd_expired;

   assign fe         = clk_sync_q[2] & ~clk_sync_q[1];
   assign wd_active  = (state_q == ST_SEND) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
   assign wd_expired = wd_active & ~fe & (wd_q == '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         clk_sync_q  <= 3'b111;
         data_sync_q <= 2'b11;
         frame_q     <= '0;
         idx_q       <= '0;
         inh_q       <= '0;
         wd_q        <= '0;
         nack_q      <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         to_q        <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[1:0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         to_q        <= 1'b0;

         if (wd_active) begin
            wd_q <= fe ? TO_LOAD : wd_q - TW'(1);
         end

         // A watchdog abort overrides whatever the current state would do this cycle.
         if (wd_expired) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            to_q      <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (tx_valid) begin
                     frame_q  <= {1'b1, ~^tx_data, tx_data};
                     inh_q    <= INH_LOAD;
                     clk_oe_q <= 1'b1;
                     ready_q  <= 1'b0;
                     state_q  <= ST_INHIBIT;
                  end
               end
               ST_INHIBIT: begin
                  if (inh_q == '0) begin
                     data_oe_q <= 1'b1;
                     state_q   <= ST_START;
                  end else begin
                     inh_q <= inh_q - IW'(1);
                  end
               end
               ST_START: begin
                  clk_oe_q <= 1'b0;
                  idx_q    <= '0;
                  wd_q     <= TO_LOAD;
                  state_q  <= ST_SEND;
               end
               ST_SEND: begin
                  if (fe) begin
                     data_oe_q <= ~frame_q[idx_q];
                     if (idx_q == 4'd9) begin
                        state_q <= ST_ACK;
                     end else begin
                        idx_q <= idx_q + 4'd1;
                     end
                  end
               end
               ST_ACK: begin
                  if (fe) begin
                     nack_q  <= data_sync_q[1];
                     state_q <= ST_WAIT_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  if (clk_sync_q[1] && data_sync_q[1]) begin
                     done_q  <= 1'b1;
                     err_q   <= nack_q;
                     ready_q <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
               default: begin
                  clk_oe_q  <= 1'b0;
                  data_oe_q <= 1'b0;
                  ready_q   <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_ready    = ready_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign done        = done_q;
   assign err         = err_q;
   assign timeout     = to_q;

endmodule

// File: tb/tb_my_ps2_tx.sv
// Bench for my_ps2_tx: PS/2 device model on open-drain lines, expected results queued at
// issue time and compared by an independent monitor on every done pulse.
module tb_my_ps2_tx;

   localparam int INH  = 200;
   localparam int TO   = 3000;
   localparam int HALF = 15;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       done;
   logic       err;
   logic       timeout;
   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;
   wire        ps2_clk  = dev_clk & ~ps2_clk_oe;
   wire        ps2_data = dev_data & ~ps2_data_oe;

   my_ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .done(done), .err(err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      int         err;
      int         to;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   n_exp  = 0;
   int   dev_mode = 0;   // 0 ACK, 1 NACK, 2 silent
   logic dev_busy = 1'b0;
   int   n_bits = 0;
   logic [9:0] got_frame = '0;
   logic start_bit = 1'b1;
   int   inh_cnt = 0;
   int   start_cnt = 0;
   int   send_cnt = 0;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic logic [9:0] exp_frame(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, b};
   endfunction

   // device model: answers a request-to-send with 11 clock pulses
   initial forever begin
      @(negedge clk);
      if (ps2_data_oe && !ps2_clk_oe && dev_mode != 2 && !dev_busy) begin
         dev_busy  = 1'b1;
         n_bits    = 0;
         start_bit = ps2_data;
         repeat (8) @(negedge clk);
         for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            got_frame[k] = ps2_data;
            n_bits++;
            repeat (HALF) @(negedge clk);
         end
         if (dev_mode == 0) dev_data = 1'b0;
         repeat (4) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk  = 1'b1;
         dev_data = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_busy = 1'b0;
      end
   end

   // monitor / scoreboard
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got=1 exp=0");
         end else begin
            e = sb.pop_front();
            chk("err", int'(err), e.err);
            chk("timeout", int'(timeout), e.to);
            chk("ready_at_done", int'(tx_ready), 1);
            chk("inhibit_cycles", inh_cnt, INH);
            chk("start_cycles", start_cnt, 1);
            if (e.to != 0) begin
               chk("timeout_cycles", send_cnt, TO);
               chk("clk_oe_abort", int'(ps2_clk_oe), 0);
               chk("data_oe_abort", int'(ps2_data_oe), 0);
            end else begin
               chk("start_bit", int'(start_bit), 0);
               chk("bits_seen", n_bits, 10);
               chk("frame", int'(got_frame), int'(exp_frame(e.b)));
            end
         end
      end else if (err || timeout) begin
         checks++;
         errors++;
         $display("FAIL stray_flags got=%0d%0d exp=00", err, timeout);
      end
      if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
      if (ps2_clk_oe && ps2_data_oe) start_cnt++;
      if (!ps2_clk_oe && ps2_data_oe) send_cnt++;
      if (tx_ready) begin
         inh_cnt   = 0;
         start_cnt = 0;
         send_cnt  = 0;
      end
   end

   task automatic send(input logic [7:0] b, input int mode, input bit track);
      int i;
      for (i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (tx_ready && !dev_busy) break;
      end
      if (i == 20000) begin
         checks++;
         errors++;
         $display("FAIL idle_wait got=busy exp=idle");
      end
      dev_mode = mode;
      if (track) begin
         sb.push_back('{b, (mode != 0) ? 1 : 0, (mode == 2) ? 1 : 0});
         n_exp++;
      end
      tx_valid = 1'b1;
      tx_data  = b;
      @(posedge clk);
      #1 tx_valid = 1'b0;
   endtask

   task automatic wait_all();
      for (int i = 0; i < 20000 && n_done < n_exp; i++) @(negedge clk);
      chk("drain", n_done, n_exp);
   endtask

   initial begin
      int d0;
      int i;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(tx_ready), 1);
      chk("rst_clk_oe", int'(ps2_clk_oe), 0);
      chk("rst_data_oe", int'(ps2_data_oe), 0);
      chk("rst_done", int'(done), 0);
      resetn = 1'b1;

      send(8'hED, 0, 1);
      wait_all();
      send(8'h00, 0, 1);
      send(8'h01, 0, 1);
      send(8'hFF, 0, 1);
      wait_all();
      send(8'h3C, 1, 1);
      wait_all();
      send(8'hA7, 2, 1);
      wait_all();

      // busy input ignored, then accepted right after done
      send(8'hF4, 0, 1);
      for (i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (dev_busy && n_bits >= 2) break;
      end
      chk("busy_reached", int'(i < 20000), 1);
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      sb.push_back('{8'h55, 0, 0});
      n_exp++;
      chk("busy_ready", int'(tx_ready), 0);
      for (i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("busy_done_seen", int'(i < 20000), 1);
      @(posedge clk);
      #1;
      chk("b2b_accept", int'(tx_ready), 0);
      tx_valid = 1'b0;
      wait_all();

      for (int k = 0; k < 10; k++) begin
         send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 1 : 0, 1);
      end
      wait_all();

      // reset in the middle of SEND
      send(8'hA5, 0, 0);
      for (i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (dev_busy && n_bits >= 3) break;
      end
      #3 resetn = 1'b0;
      #1;
      chk("midrst_clk_oe", int'(ps2_clk_oe), 0);
      chk("midrst_data_oe", int'(ps2_data_oe), 0);
      chk("midrst_ready", int'(tx_ready), 1);
      d0 = n_done;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      for (i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (!dev_busy) break;
      end
      repeat (50) @(negedge clk);
      chk("midrst_no_done", n_done, d0);

      send(8'h12, 0, 1);
      wait_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL global_time_limit got=expired exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "time limit");
   end

endmodule
